// File: rtl/mod_updown_counter.sv
// Modulo-(MAX_VAL+1) up/down counter with synchronous load and clear.
// Boundary mode is wrap or saturate. A boundary event raises a one-cycle tc
// pulse, flips toggle and bumps a saturating event counter. All outputs come
// straight from registers, so no input reaches an output within a cycle.
module mod_updown_counter #(
    parameter int              WIDTH     = 8,
    parameter longint unsigned MAX_VAL   = 255,
    parameter bit              SATURATE  = 1'b0,
    parameter longint unsigned RESET_VAL = 0,
    parameter int              EVT_WIDTH = 8
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 enable,
    input  logic                 up_dn,
    input  logic                 load,
    input  logic [WIDTH-1:0]     load_val,
    input  logic                 clear,
    output logic [WIDTH-1:0]     count,
    output logic                 tc,
    output logic                 toggle,
    output logic [EVT_WIDTH-1:0] evt_cnt
);

    // Parameter sanity. A 64-bit shift keeps the range test valid at WIDTH=32.
    if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
        $fatal(1, "mod_updown_counter: WIDTH must be in 2..32");
    end
    if (MAX_VAL >= (64'd1 << WIDTH)) begin : g_bad_max
        $fatal(1, "mod_updown_counter: MAX_VAL must be < 2**WIDTH");
    end
    if (RESET_VAL > MAX_VAL) begin : g_bad_reset
        $fatal(1, "mod_updown_counter: RESET_VAL must be <= MAX_VAL");
    end
    if (EVT_WIDTH < 1) begin : g_bad_evt
        $fatal(1, "mod_updown_counter: EVT_WIDTH must be >= 1");
    end

    localparam logic [WIDTH-1:0]     MAX_C   = WIDTH'(MAX_VAL);
    localparam logic [WIDTH-1:0]     RESET_C = WIDTH'(RESET_VAL);
    localparam logic [WIDTH-1:0]     ONE_C   = WIDTH'(1);
    localparam logic [EVT_WIDTH-1:0] EVT_ONE = EVT_WIDTH'(1);
    localparam logic [EVT_WIDTH-1:0] EVT_TOP = '1;

    logic [WIDTH-1:0]     count_reg, count_next;
    logic                 tc_reg, tc_next;
    logic                 toggle_reg, toggle_next;
    logic [EVT_WIDTH-1:0] evt_reg, evt_next;
    logic                 at_limit;

    // Next-state: clear > load > enable > hold. A step into the limit in the
    // current direction is a boundary event, whatever the wrap/saturate mode.
    always_comb begin
        count_next  = count_reg;
        tc_next     = 1'b0;
        toggle_next = toggle_reg;
        evt_next    = evt_reg;
        at_limit    = up_dn ? (count_reg == MAX_C) : (count_reg == '0);

        if (clear) begin
            count_next  = RESET_C;
            toggle_next = 1'b0;
            evt_next    = '0;
        end else if (load) begin
            count_next = (load_val > MAX_C) ? MAX_C : load_val;
        end else if (enable) begin
            if (at_limit) begin
                tc_next     = 1'b1;
                toggle_next = ~toggle_reg;
                evt_next    = (evt_reg == EVT_TOP) ? evt_reg : evt_reg + EVT_ONE;
                if (!SATURATE) begin
                    count_next = up_dn ? '0 : MAX_C;
                end
            end else begin
                count_next = up_dn ? count_reg + ONE_C : count_reg - ONE_C;
            end
        end
    end

    // State register with synchronous reset overriding every other input.
    always_ff @(posedge clock) begin
        if (reset) begin
            count_reg  <= RESET_C;
            tc_reg     <= 1'b0;
            toggle_reg <= 1'b0;
            evt_reg    <= '0;
        end else begin
            count_reg  <= count_next;
            tc_reg     <= tc_next;
            toggle_reg <= toggle_next;
            evt_reg    <= evt_next;
        end
    end

    assign count   = count_reg;
    assign tc      = tc_reg;
    assign toggle  = toggle_reg;
    assign evt_cnt = evt_reg;

endmodule

// File: tb/tb_mod_updown_counter.sv
// Directed bench for mod_updown_counter. Three instances share one stimulus
// bus: a wrapping counter (0..9, reset value 3), a saturating counter (0..9)
// and a 2-bit wrapping counter with a 2-bit event counter. Each phase resets
// everything and then checks one instance against hand-computed values.
module tb_mod_updown_counter;

    logic       clk = 1'b0;
    logic       reset, enable, up_dn, load, clear;
    logic [3:0] load_val;

    logic [3:0] a_count;  logic a_tc, a_tog; logic [7:0] a_evt;
    logic [3:0] s_count;  logic s_tc, s_tog; logic [7:0] s_evt;
    logic [1:0] e_count;  logic e_tc, e_tog; logic [1:0] e_evt;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    mod_updown_counter #(.WIDTH(4), .MAX_VAL(9), .SATURATE(1'b0), .RESET_VAL(3), .EVT_WIDTH(8)) dut_a (
        .clock(clk), .reset(reset), .enable(enable), .up_dn(up_dn), .load(load),
        .load_val(load_val), .clear(clear), .count(a_count), .tc(a_tc),
        .toggle(a_tog), .evt_cnt(a_evt));

    mod_updown_counter #(.WIDTH(4), .MAX_VAL(9), .SATURATE(1'b1), .RESET_VAL(0), .EVT_WIDTH(8)) dut_s (
        .clock(clk), .reset(reset), .enable(enable), .up_dn(up_dn), .load(load),
        .load_val(load_val), .clear(clear), .count(s_count), .tc(s_tc),
        .toggle(s_tog), .evt_cnt(s_evt));

    mod_updown_counter #(.WIDTH(2), .MAX_VAL(3), .SATURATE(1'b0), .RESET_VAL(0), .EVT_WIDTH(2)) dut_e (
        .clock(clk), .reset(reset), .enable(enable), .up_dn(up_dn), .load(load),
        .load_val(load_val[1:0]), .clear(clear), .count(e_count), .tc(e_tc),
        .toggle(e_tog), .evt_cnt(e_evt));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
        end else begin
            $display("[TB] ok   %s = %0d", tag, got);
        end
    endtask

    // Apply one cycle of inputs, then sample #1 after the edge.
    task automatic step(input logic rst, input logic en, input logic ud,
                        input logic ld, input logic [3:0] lv, input logic clr);
        reset = rst; enable = en; up_dn = ud; load = ld; load_val = lv; clear = clr;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; enable = 1'b0; up_dn = 1'b1; load = 1'b0; load_val = '0; clear = 1'b0;

        // ---- Reset and clear (instance a) ----
        step(1, 1, 1, 0, 0, 0);
        step(1, 1, 1, 0, 0, 0);
        check("a_rst_count", a_count, 3);
        check("a_rst_tc", a_tc, 0);
        check("a_rst_toggle", a_tog, 0);
        check("a_rst_evt", a_evt, 0);
        for (int i = 0; i < 4; i++) step(0, 1, 1, 0, 0, 0);
        check("a_run_to_7", a_count, 7);
        step(0, 1, 1, 0, 0, 1);
        check("a_clear_count", a_count, 3);
        check("a_clear_evt", a_evt, 0);

        // ---- Up wrap: from 0, 12 steps -> 1..9,0,1,2 ----
        step(0, 0, 1, 1, 0, 0);
        check("a_load0", a_count, 0);
        for (int i = 1; i <= 12; i++) begin
            step(0, 1, 1, 0, 0, 0);
            check($sformatf("a_up%0d_count", i), a_count, i % 10);
            check($sformatf("a_up%0d_tc", i), a_tc, (i == 10) ? 1 : 0);
        end
        check("a_up_toggle", a_tog, 1);
        check("a_up_evt", a_evt, 1);

        // ---- Down wrap and direction change ----
        step(0, 0, 1, 0, 0, 1);
        step(0, 0, 1, 1, 1, 0);
        check("a_load1", a_count, 1);
        step(0, 1, 0, 0, 0, 0); check("a_dn1_count", a_count, 0); check("a_dn1_tc", a_tc, 0);
        step(0, 1, 0, 0, 0, 0); check("a_dn2_count", a_count, 9); check("a_dn2_tc", a_tc, 1);
        check("a_dn2_toggle", a_tog, 1);
        step(0, 1, 0, 0, 0, 0); check("a_dn3_count", a_count, 8); check("a_dn3_tc", a_tc, 0);
        step(0, 1, 1, 0, 0, 0); check("a_upA_count", a_count, 9); check("a_upA_tc", a_tc, 0);
        step(0, 1, 1, 0, 0, 0); check("a_upB_count", a_count, 0); check("a_upB_tc", a_tc, 1);
        check("a_dir_toggle", a_tog, 0);
        check("a_dir_evt", a_evt, 2);

        // ---- Load clamp and priority ----
        step(0, 1, 1, 1, 14, 0);
        check("a_clamp_count", a_count, 9);
        check("a_clamp_tc", a_tc, 0);
        check("a_clamp_evt", a_evt, 2);
        step(0, 1, 1, 1, 5, 1);
        check("a_clr_over_load", a_count, 3);
        step(0, 1, 1, 1, 6, 0);
        check("a_load6", a_count, 6);
        step(0, 0, 1, 0, 0, 0);
        check("a_hold_count", a_count, 6);
        check("a_hold_tc", a_tc, 0);
        step(1, 1, 1, 1, 8, 1);
        check("a_midrst_count", a_count, 3);

        // ---- Saturate (instance s) ----
        step(1, 0, 1, 0, 0, 0);
        step(0, 0, 1, 1, 7, 0);
        check("s_load7", s_count, 7);
        for (int i = 1; i <= 5; i++) begin
            step(0, 1, 1, 0, 0, 0);
            check($sformatf("s_up%0d_count", i), s_count, (i == 1) ? 8 : 9);
            check($sformatf("s_up%0d_tc", i), s_tc, (i >= 3) ? 1 : 0);
            if (i >= 3) check($sformatf("s_up%0d_toggle", i), s_tog, (i == 4) ? 0 : 1);
        end
        check("s_up_evt", s_evt, 3);
        step(0, 0, 1, 1, 0, 0);
        check("s_load0_tc", s_tc, 0);
        step(0, 1, 0, 0, 0, 0);
        check("s_dn_hold_count", s_count, 0);
        check("s_dn_hold_tc", s_tc, 1);
        check("s_dn_evt", s_evt, 4);

        // ---- Event counter saturation (instance e) ----
        step(1, 0, 1, 0, 0, 0);
        for (int i = 1; i <= 20; i++) begin
            step(0, 1, 1, 0, 0, 0);
            check($sformatf("e_up%0d_count", i), e_count, i % 4);
            if (i % 4 == 0) begin
                check($sformatf("e_up%0d_tc", i), e_tc, 1);
                check($sformatf("e_up%0d_evt", i), e_evt, (i / 4 >= 3) ? 3 : i / 4);
            end
        end
        check("e_toggle_end", e_tog, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
